// File: rtl/load_scoreboard_hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : load_scoreboard_hazard_unit_pkg
// Purpose : Opcode, ALU-op and EX control-bundle definitions shared by the
//           ID-stage hazard unit and its decoder.
// Revision: 1.0 - initial release
// ============================================================================
package load_scoreboard_hazard_unit_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_BR   = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    typedef struct packed {
        logic       branch;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/load_scoreboard_hazard_unit_main_control_decoder.sv
`default_nettype none
// ============================================================================
// Module  : main_control_decoder
// Purpose : Combinational opcode decode into the EX control bundle plus
//           source-register usage flags.
// Revision: 1.0 - initial release
// ============================================================================
module main_control_decoder
    import load_scoreboard_hazard_unit_pkg::*;
(
    input  logic [6:0] opcode,
    output ctrl_t      ctrl,
    output logic       uses_rs1,
    output logic       uses_rs2
);

    always_comb begin
        ctrl     = '0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl.alu_op    = ALUOP_FUNC;
                ctrl.reg_write = 1'b1;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
            end
            OP_I: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                uses_rs1       = 1'b1;
            end
            OP_LOAD: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                uses_rs1        = 1'b1;
            end
            OP_STORE: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALUOP_BR;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
            end
            default: begin
                ctrl     = '0;
                uses_rs1 = 1'b0;
                uses_rs2 = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_scoreboard_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module  : load_scoreboard_hazard_unit
// Purpose : ID-stage control with per-register load-latency scoreboard,
//           load-use stall, branch flush and saturating stall counter.
// Revision: 1.0 - initial release
// ============================================================================
module load_scoreboard_hazard_unit
    import load_scoreboard_hazard_unit_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int LOAD_LATENCY = 1,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [6:0]             id_opcode,
    input  logic [REG_ADDR_W-1:0]  id_rs1,
    input  logic [REG_ADDR_W-1:0]  id_rs2,
    input  logic [REG_ADDR_W-1:0]  id_rd,
    input  logic                   branch_taken,
    output logic                   stall,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   if_id_flush,
    output logic                   branch,
    output logic                   reg_write,
    output logic                   mem_to_reg,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   alu_src,
    output logic [1:0]             alu_op,
    output logic [NUM_REGS-1:0]    busy_vec,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam int              CNT_W       = $clog2(LOAD_LATENCY + 1);
    localparam logic [CNT_W-1:0] C_LOAD_INIT = CNT_W'(LOAD_LATENCY);

    ctrl_t                  w_dec_ctrl;
    ctrl_t                  w_ex_ctrl;
    logic                   w_uses_rs1;
    logic                   w_uses_rs2;
    logic                   w_rs1_busy;
    logic                   w_rs2_busy;
    logic                   w_hz;
    logic                   w_load_issue;
    logic [CNT_W-1:0]       r_cnt [NUM_REGS];
    logic [STALL_CNT_W-1:0] r_stall_cycles;

    main_control_decoder u_decoder (
        .opcode   (id_opcode),
        .ctrl     (w_dec_ctrl),
        .uses_rs1 (w_uses_rs1),
        .uses_rs2 (w_uses_rs2)
    );

    assign w_rs1_busy = w_uses_rs1 && (id_rs1 != '0) && (r_cnt[id_rs1] != '0);
    assign w_rs2_busy = w_uses_rs2 && (id_rs2 != '0) && (r_cnt[id_rs2] != '0);
    assign w_hz       = id_valid && !branch_taken && (w_rs1_busy || w_rs2_busy);

    // Only loads that actually leave ID (not stalled, not squashed) are tracked.
    assign w_load_issue = id_valid && !w_hz && !branch_taken
                          && (id_opcode == OP_LOAD) && (id_rd != '0);

    assign stall       = !reset && w_hz;
    assign pc_write    = !reset && !w_hz;
    assign if_id_write = !reset && !w_hz;
    assign if_id_flush = !reset && branch_taken;

    assign w_ex_ctrl  = (reset || w_hz || branch_taken) ? ctrl_t'('0) : w_dec_ctrl;
    assign branch     = w_ex_ctrl.branch;
    assign reg_write  = w_ex_ctrl.reg_write;
    assign mem_to_reg = w_ex_ctrl.mem_to_reg;
    assign mem_read   = w_ex_ctrl.mem_read;
    assign mem_write  = w_ex_ctrl.mem_write;
    assign alu_src    = w_ex_ctrl.alu_src;
    assign alu_op     = w_ex_ctrl.alu_op;

    // A reissued load onto a pending register reloads rather than decrements.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i == 0) begin
                    r_cnt[i] <= '0;
                end else if (w_load_issue && (id_rd == REG_ADDR_W'(i))) begin
                    r_cnt[i] <= C_LOAD_INIT;
                end else if (r_cnt[i] != '0) begin
                    r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            busy_vec[i] = (r_cnt[i] != '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (w_hz && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
        end
    end

    assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_load_scoreboard_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_load_scoreboard_hazard_unit
// Purpose : Three parameterisations driven by one stimulus stream and compared
//           against a timestamp-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_load_scoreboard_hazard_unit;

    localparam logic [6:0] T_R   = 7'b0110011;
    localparam logic [6:0] T_I   = 7'b0010011;
    localparam logic [6:0] T_LD  = 7'b0000011;
    localparam logic [6:0] T_ST  = 7'b0100011;
    localparam logic [6:0] T_BR  = 7'b1100011;
    localparam logic [6:0] T_JAL = 7'b1101111;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       branch_taken;

    logic [2:0]       stall, pc_write, if_id_write, if_id_flush;
    logic [2:0][7:0]  ctrl;
    logic [2:0][31:0] busy;
    logic [15:0]      sc0, sc1;
    logic [1:0]       sc2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ready [3][32];
    int scnt  [3];
    int lat   [3] = '{1, 3, 2};
    int smax  [3] = '{65535, 65535, 3};

    load_scoreboard_hazard_unit #(.LOAD_LATENCY(1), .STALL_CNT_W(16)) u_l1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .branch_taken(branch_taken),
        .stall(stall[0]), .pc_write(pc_write[0]), .if_id_write(if_id_write[0]),
        .if_id_flush(if_id_flush[0]), .branch(ctrl[0][7]), .reg_write(ctrl[0][6]),
        .mem_to_reg(ctrl[0][5]), .mem_read(ctrl[0][4]), .mem_write(ctrl[0][3]),
        .alu_src(ctrl[0][2]), .alu_op(ctrl[0][1:0]), .busy_vec(busy[0]),
        .stall_cycles(sc0)
    );

    load_scoreboard_hazard_unit #(.LOAD_LATENCY(3), .STALL_CNT_W(16)) u_l3 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .branch_taken(branch_taken),
        .stall(stall[1]), .pc_write(pc_write[1]), .if_id_write(if_id_write[1]),
        .if_id_flush(if_id_flush[1]), .branch(ctrl[1][7]), .reg_write(ctrl[1][6]),
        .mem_to_reg(ctrl[1][5]), .mem_read(ctrl[1][4]), .mem_write(ctrl[1][3]),
        .alu_src(ctrl[1][2]), .alu_op(ctrl[1][1:0]), .busy_vec(busy[1]),
        .stall_cycles(sc1)
    );

    load_scoreboard_hazard_unit #(.LOAD_LATENCY(2), .STALL_CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .branch_taken(branch_taken),
        .stall(stall[2]), .pc_write(pc_write[2]), .if_id_write(if_id_write[2]),
        .if_id_flush(if_id_flush[2]), .branch(ctrl[2][7]), .reg_write(ctrl[2][6]),
        .mem_to_reg(ctrl[2][5]), .mem_read(ctrl[2][4]), .mem_write(ctrl[2][3]),
        .alu_src(ctrl[2][2]), .alu_op(ctrl[2][1:0]), .busy_vec(busy[2]),
        .stall_cycles(sc2)
    );

    always #5 clk = ~clk;

    // {branch, reg_write, mem_to_reg, mem_read, mem_write, alu_src, alu_op, uses_rs1, uses_rs2}
    function automatic logic [9:0] decode(input logic [6:0] op);
        case (op)
            T_R:     return {8'b0100_0010, 2'b11};
            T_I:     return {8'b0100_0100, 2'b10};
            T_LD:    return {8'b0111_0100, 2'b10};
            T_ST:    return {8'b0000_1100, 2'b11};
            T_BR:    return {8'b1000_0001, 2'b11};
            default: return 10'b0;
        endcase
    endfunction

    function automatic logic [63:0] sc_obs(input int k);
        case (k)
            0:       return 64'(sc0);
            1:       return 64'(sc1);
            default: return 64'(sc2);
        endcase
    endfunction

    task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[u%0d] cyc=%0d: observed %0h expected %0h", tag, k, cyc, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            scnt[k] = 0;
            for (int r = 0; r < 32; r++) ready[k][r] = -1;
        end
    endtask

    task automatic reset_check();
        for (int k = 0; k < 3; k++) begin
            chk("rst_stall", k, 64'(stall[k]), 64'd0);
            chk("rst_pc_write", k, 64'(pc_write[k]), 64'd0);
            chk("rst_if_id_write", k, 64'(if_id_write[k]), 64'd0);
            chk("rst_flush", k, 64'(if_id_flush[k]), 64'd0);
            chk("rst_ctrl", k, 64'(ctrl[k]), 64'd0);
            chk("rst_busy", k, 64'(busy[k]), 64'd0);
            chk("rst_stall_cycles", k, sc_obs(k), 64'd0);
        end
    endtask

    task automatic step(input bit v, input logic [6:0] op, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] rd, input bit br);
        logic [9:0]  d;
        logic [31:0] b;
        bit          hz [3];
        id_valid = v; id_opcode = op; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        branch_taken = br;
        @(negedge clk);
        d = decode(op);
        for (int k = 0; k < 3; k++) begin
            hz[k] = v && !br && ((d[1] && r1 != 0 && cyc <= ready[k][r1]) ||
                                 (d[0] && r2 != 0 && cyc <= ready[k][r2]));
            b = '0;
            for (int r = 1; r < 32; r++) b[r] = (cyc <= ready[k][r]);
            chk("stall", k, 64'(stall[k]), 64'(hz[k]));
            chk("pc_write", k, 64'(pc_write[k]), 64'(!hz[k]));
            chk("if_id_write", k, 64'(if_id_write[k]), 64'(!hz[k]));
            chk("if_id_flush", k, 64'(if_id_flush[k]), 64'(br));
            chk("ctrl", k, 64'(ctrl[k]), (hz[k] || br) ? 64'd0 : 64'(d[9:2]));
            chk("busy_vec", k, 64'(busy[k]), 64'(b));
            chk("stall_cycles", k, sc_obs(k), 64'(scnt[k]));
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (v && !br && !hz[k] && op == T_LD && rd != 0) ready[k][rd] = cyc + lat[k];
            if (hz[k] && scnt[k] < smax[k]) scnt[k]++;
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        branch_taken = 1'b1;
        #2;
        reset_check();
        model_clear();
        id_valid = 1'b0;
        branch_taken = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        logic [6:0] op;
        clk = 1'b0; reset = 1'b1;
        id_valid = 1'b1; id_opcode = T_R; id_rs1 = 5'd5; id_rs2 = 5'd5; id_rd = 5'd6;
        branch_taken = 1'b1;
        model_clear();
        #12;
        reset_check();
        id_valid = 1'b0; branch_taken = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Load-use on x5, dependent add held in ID until it issues everywhere
        step(1, T_LD, 5'd1, 5'd0, 5'd5, 0);
        repeat (4) step(1, T_R, 5'd5, 5'd1, 5'd6, 0);
        // ld x7 then sd x7
        step(1, T_LD, 5'd2, 5'd0, 5'd7, 0);
        repeat (5) step(1, T_ST, 5'd2, 5'd7, 5'd0, 0);
        // ld x0 never tracked
        step(1, T_LD, 5'd2, 5'd0, 5'd0, 0);
        repeat (2) step(1, T_R, 5'd0, 5'd0, 5'd1, 0);
        // I-type ignores rs2 field
        step(1, T_LD, 5'd2, 5'd0, 5'd9, 0);
        step(1, T_I, 5'd4, 5'd9, 5'd3, 0);
        repeat (3) step(0, T_JAL, 5'd9, 5'd9, 5'd0, 0);
        // Flush overrides hazard; squashed load leaves no entry
        step(1, T_LD, 5'd1, 5'd0, 5'd5, 0);
        step(1, T_R, 5'd5, 5'd5, 5'd6, 1);
        step(1, T_LD, 5'd1, 5'd0, 5'd8, 1);
        step(1, T_R, 5'd8, 5'd8, 5'd1, 0);
        repeat (3) step(1, T_BR, 5'd5, 5'd8, 5'd0, 0);
        // Reload of a pending register restarts its countdown
        step(1, T_LD, 5'd1, 5'd0, 5'd5, 0);
        step(1, T_JAL, 5'd5, 5'd5, 5'd2, 0);
        step(1, T_LD, 5'd1, 5'd0, 5'd5, 0);
        repeat (5) step(1, T_R, 5'd1, 5'd5, 5'd6, 0);
        // Asynchronous reset mid-countdown
        step(1, T_LD, 5'd1, 5'd0, 5'd5, 0);
        step(1, T_JAL, 5'd0, 5'd0, 5'd0, 0);
        do_reset();
        step(1, T_R, 5'd5, 5'd5, 5'd6, 0);

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 5))
                0:       op = T_R;
                1:       op = T_I;
                2:       op = T_LD;
                3:       op = T_ST;
                4:       op = T_BR;
                default: op = 7'($urandom);
            endcase
            step($urandom_range(0, 7) != 0, op, 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 $urandom_range(0, 9) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
